ballot_sequencer: RTL and testbench
===================================

BALLOT_SEQUENCER -- requirements
Module: ballot_sequencer

Interface
REQ-001 SHALL have parameter LOCKOUT_CYCLES, default 10: number of post-vote lockout cycles, legal range 1..255.
REQ-002 SHALL have parameter DISPLAY_CYCLES, default 50: dwell cycles per candidate in results display, legal range 1..65535.
REQ-003 SHALL have port clock, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port session_open, input, 1: officer level; 1 = polls open.
REQ-006 SHALL have port ballot_arm, input, 1: officer pulse arming exactly one ballot.
REQ-007 SHALL have port vote_valid, input, 4: per-candidate one-cycle debounced press pulses; bit i = candidate i.
REQ-008 SHALL have port vote_counts, input, 32: logger tallies, candidate i at bits [8i+7:8i].
REQ-009 SHALL have port vote_inc, output, 4: one-hot, one-cycle increment strobe to logger.
REQ-010 SHALL have port ballot_ready, output, 1: ballot armed and awaiting a press.
REQ-011 SHALL have port busy, output, 1: lockout in progress; drives the all-on LED pattern.
REQ-012 SHALL have port total_ballots, output, 8: accepted ballots this session.
REQ-013 SHALL have port result_sel, output, 2: candidate currently displayed.
REQ-014 SHALL have port result_count, output, 8: tally of result_sel.
REQ-015 SHALL have port winner, output, 2: index of the highest tally.
REQ-016 SHALL have port tie, output, 1: another candidate equals the winner's tally.
REQ-017 SHALL have port results_valid, output, 1: winner, tie and result outputs are meaningful.
REQ-018 SHALL have port rejected_cnt, output, 8: count of rejected presses.

Function
REQ-019 SHALL implement FSM states CLOSED, IDLE, ARMED, LOCKOUT, TALLY and RESULTS; reset state is CLOSED.
REQ-020 CLOSED: session_open=1 -> IDLE next cycle; all presses ignored and not counted as rejected.
REQ-021 IDLE: ballot_arm=1 and total_ballots<255 -> ARMED; ballot_arm ignored when total_ballots==255.
REQ-022 ARMED: ballot_ready=1; vote_valid with exactly one bit set -> vote_inc equals that bit on the next cycle (latency 1), total_ballots+1, then LOCKOUT.
REQ-023 ARMED: vote_valid with two or more bits set -> no vote_inc, rejected_cnt+1, remain ARMED.
REQ-024 ARMED: ballot_arm re-asserted -> no effect.
REQ-025 IDLE or LOCKOUT: any nonzero vote_valid -> rejected_cnt+1, no vote_inc.
REQ-026 LOCKOUT: busy=1 for exactly LOCKOUT_CYCLES cycles, then IDLE if session_open=1, else TALLY.
REQ-027 IDLE or ARMED with session_open=0 -> TALLY. In ARMED, closing takes priority over a same-cycle vote: the vote is dropped and not counted as rejected.
REQ-028 TALLY: scan candidates 0..3 over exactly 4 cycles, then RESULTS.
REQ-029 Winner: the maximum tally; on equal tallies the lowest index wins and tie=1.
REQ-030 RESULTS: results_valid=1; result_sel starts at 0 and advances every DISPLAY_CYCLES cycles, wrapping 3->0.
REQ-031 RESULTS: result_count tracks vote_counts[result_sel] combinationally.
REQ-032 RESULTS: session_open=1 -> IDLE, results_valid=0, total_ballots retained.
REQ-033 total_ballots and rejected_cnt SHALL saturate at 255.
REQ-034 vote_inc SHALL be 0 in every cycle other than the cycle after an accepted vote.

Reset
REQ-035 reset SHALL take priority over all other inputs, including mid-lockout and mid-tally.
REQ-036 On reset, all outputs SHALL be 0: vote_inc, ballot_ready, busy, total_ballots, result_sel, winner, tie, results_valid, rejected_cnt. result_count follows vote_counts[7:0].
REQ-037 On reset, all internal counters SHALL clear and the FSM SHALL return to CLOSED.

Configuration
REQ-038 With VOTE_AUDIT_EN defined, rejected_cnt SHALL operate per REQ-023, REQ-025 and REQ-033.
REQ-039 With VOTE_AUDIT_EN undefined, rejected_cnt SHALL be tied to 0 and no counter logic SHALL be synthesized; all other behaviour is unchanged.

Verification
REQ-040 Open, arm, pulse vote_valid=4'b0100 -> vote_inc=4'b0100 one cycle later, busy=1 for 10 cycles, total_ballots=1, then IDLE.
REQ-041 Armed, vote_valid=4'b0011 -> vote_inc stays 0, rejected_cnt=1, ballot_ready stays 1; then 4'b0001 -> accepted.
REQ-042 Press while unarmed and again during lockout -> rejected_cnt=2, no vote_inc; repeat with VOTE_AUDIT_EN undefined -> rejected_cnt=0.
REQ-043 Close with vote_counts={8'd5,8'd9,8'd9,8'd2} (cand3..cand0) -> after 4 TALLY cycles winner=1, tie=1, results_valid=1; result_sel steps 0,1,2,3,0 every 50 cycles.
REQ-044 Drive total_ballots to 255 -> further ballot_arm ignored, ballot_ready stays 0; assert reset mid-LOCKOUT -> all outputs 0 next cycle, state CLOSED.

Source files
------------

// File: rtl/ballot_sequencer.sv
// ballot_sequencer: front-panel sequencer for a four-candidate voting machine.
// Arms one ballot at a time, forwards a single accepted press to the tally
// logger, enforces a post-vote lockout, then scans the logger's tallies to
// pick a winner and cycles through the per-candidate results.
// Optional feature: define VOTE_AUDIT_EN to build the rejected-press counter;
// without it rejected_cnt is tied to zero.
//
// Input pulse contract: vote_valid bits and ballot_arm are one-cycle pulses
// sampled on the rising clock edge; each pulse is acted on exactly once and
// there is no backpressure. vote_inc is a one-cycle strobe the logger must
// accept unconditionally.
module ballot_sequencer #(
    parameter int LOCKOUT_CYCLES = 10,
    parameter int DISPLAY_CYCLES = 50
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        session_open,
    input  logic        ballot_arm,
    input  logic [3:0]  vote_valid,
    input  logic [31:0] vote_counts,
    output logic [3:0]  vote_inc,
    output logic        ballot_ready,
    output logic        busy,
    output logic [7:0]  total_ballots,
    output logic [1:0]  result_sel,
    output logic [7:0]  result_count,
    output logic [1:0]  winner,
    output logic        tie,
    output logic        results_valid,
    output logic [7:0]  rejected_cnt,
    output logic [2:0]  state_dbg
);

    localparam logic [2:0] S_CLOSED  = 3'd0;
    localparam logic [2:0] S_IDLE    = 3'd1;
    localparam logic [2:0] S_ARMED   = 3'd2;
    localparam logic [2:0] S_LOCKOUT = 3'd3;
    localparam logic [2:0] S_TALLY   = 3'd4;
    localparam logic [2:0] S_RESULTS = 3'd5;

    localparam logic [7:0]  LOCK_LAST  = 8'(LOCKOUT_CYCLES - 1);
    localparam logic [15:0] DWELL_LAST = 16'(DISPLAY_CYCLES - 1);

    logic [2:0]  state_q, state_d;
    logic [3:0]  vote_inc_q, vote_inc_d;
    logic [7:0]  total_q, total_d;
    logic [7:0]  lock_cnt_q, lock_cnt_d;
    logic [1:0]  scan_idx_q, scan_idx_d;
    logic [1:0]  best_idx_q, best_idx_d;
    logic [7:0]  best_val_q, best_val_d;
    logic        tie_q, tie_d;
    logic [1:0]  result_sel_q, result_sel_d;
    logic [15:0] dwell_q, dwell_d;

    logic        vote_multi;
    logic        vote_one_hot;
    logic [7:0]  tally_val;

    // Classify the press: two or more bits set is an ambiguous press.
    always_comb begin
        vote_multi   = (vote_valid & (vote_valid - 4'd1)) != 4'd0;
        vote_one_hot = (vote_valid != 4'd0) && !vote_multi;
        tally_val    = vote_counts[{scan_idx_q, 3'b000} +: 8];
    end

    // Next-state, ballot accounting, tally scan and results display.
    always_comb begin
        state_d      = state_q;
        vote_inc_d   = 4'd0;
        total_d      = total_q;
        lock_cnt_d   = lock_cnt_q;
        scan_idx_d   = scan_idx_q;
        best_idx_d   = best_idx_q;
        best_val_d   = best_val_q;
        tie_d        = tie_q;
        result_sel_d = result_sel_q;
        dwell_d      = dwell_q;

        case (state_q)
            S_CLOSED: begin
                if (session_open) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (!session_open) begin
                    state_d    = S_TALLY;
                    scan_idx_d = 2'd0;
                end else if (ballot_arm && (total_q != 8'hFF)) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                // Closing the polls wins over a press in the same cycle.
                if (!session_open) begin
                    state_d    = S_TALLY;
                    scan_idx_d = 2'd0;
                end else if (vote_one_hot) begin
                    vote_inc_d = vote_valid;
                    total_d    = (total_q == 8'hFF) ? total_q : total_q + 8'd1;
                    lock_cnt_d = 8'd0;
                    state_d    = S_LOCKOUT;
                end
            end
            S_LOCKOUT: begin
                if (lock_cnt_q == LOCK_LAST) begin
                    lock_cnt_d = 8'd0;
                    if (session_open) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d    = S_TALLY;
                        scan_idx_d = 2'd0;
                    end
                end else begin
                    lock_cnt_d = lock_cnt_q + 8'd1;
                end
            end
            S_TALLY: begin
                // Strict greater-than keeps the lowest index on equal tallies.
                if (scan_idx_q == 2'd0) begin
                    best_idx_d = 2'd0;
                    best_val_d = tally_val;
                    tie_d      = 1'b0;
                end else if (tally_val > best_val_q) begin
                    best_idx_d = scan_idx_q;
                    best_val_d = tally_val;
                    tie_d      = 1'b0;
                end else if (tally_val == best_val_q) begin
                    tie_d = 1'b1;
                end
                if (scan_idx_q == 2'd3) begin
                    state_d      = S_RESULTS;
                    result_sel_d = 2'd0;
                    dwell_d      = 16'd0;
                end else begin
                    scan_idx_d = scan_idx_q + 2'd1;
                end
            end
            S_RESULTS: begin
                if (session_open) begin
                    state_d      = S_IDLE;
                    result_sel_d = 2'd0;
                    dwell_d      = 16'd0;
                end else if (dwell_q == DWELL_LAST) begin
                    dwell_d      = 16'd0;
                    result_sel_d = result_sel_q + 2'd1;
                end else begin
                    dwell_d = dwell_q + 16'd1;
                end
            end
            default: begin
                state_d = S_CLOSED;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_CLOSED;
            vote_inc_q   <= 4'd0;
            total_q      <= 8'd0;
            lock_cnt_q   <= 8'd0;
            scan_idx_q   <= 2'd0;
            best_idx_q   <= 2'd0;
            best_val_q   <= 8'd0;
            tie_q        <= 1'b0;
            result_sel_q <= 2'd0;
            dwell_q      <= 16'd0;
        end else begin
            state_q      <= state_d;
            vote_inc_q   <= vote_inc_d;
            total_q      <= total_d;
            lock_cnt_q   <= lock_cnt_d;
            scan_idx_q   <= scan_idx_d;
            best_idx_q   <= best_idx_d;
            best_val_q   <= best_val_d;
            tie_q        <= tie_d;
            result_sel_q <= result_sel_d;
            dwell_q      <= dwell_d;
        end
    end

`ifdef VOTE_AUDIT_EN
    logic [7:0] rej_q, rej_d;
    logic       press_reject;

    // A press is rejected when no ballot is armed, or when it is ambiguous.
    always_comb begin
        press_reject = 1'b0;
        case (state_q)
            S_IDLE:    press_reject = (vote_valid != 4'd0);
            S_ARMED:   press_reject = session_open && vote_multi;
            S_LOCKOUT: press_reject = (vote_valid != 4'd0);
            default:   press_reject = 1'b0;
        endcase
        rej_d = (press_reject && (rej_q != 8'hFF)) ? rej_q + 8'd1 : rej_q;
    end

    // Saturating rejected-press counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            rej_q <= 8'd0;
        end else begin
            rej_q <= rej_d;
        end
    end

    assign rejected_cnt = rej_q;
`else
    assign rejected_cnt = 8'd0;
`endif

    assign vote_inc      = vote_inc_q;
    assign ballot_ready  = (state_q == S_ARMED);
    assign busy          = (state_q == S_LOCKOUT);
    assign results_valid = (state_q == S_RESULTS);
    assign total_ballots = total_q;
    assign result_sel    = result_sel_q;
    assign result_count  = vote_counts[{result_sel_q, 3'b000} +: 8];
    assign winner        = best_idx_q;
    assign tie           = tie_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_ballot_sequencer.sv
// Directed bench for ballot_sequencer with hand-computed expectations.
// Follows VOTE_AUDIT_EN the same way the design does.
module tb_ballot_sequencer;

    localparam logic [2:0] S_CLOSED  = 3'd0;
    localparam logic [2:0] S_IDLE    = 3'd1;
    localparam logic [2:0] S_ARMED   = 3'd2;
    localparam logic [2:0] S_LOCKOUT = 3'd3;
    localparam logic [2:0] S_TALLY   = 3'd4;
    localparam logic [2:0] S_RESULTS = 3'd5;

`ifdef VOTE_AUDIT_EN
    localparam bit AUDIT = 1'b1;
`else
    localparam bit AUDIT = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        session_open;
    logic        ballot_arm;
    logic [3:0]  vote_valid;
    logic [31:0] vote_counts;
    logic [3:0]  vote_inc;
    logic        ballot_ready;
    logic        busy;
    logic [7:0]  total_ballots;
    logic [1:0]  result_sel;
    logic [7:0]  result_count;
    logic [1:0]  winner;
    logic        tie;
    logic        results_valid;
    logic [7:0]  rejected_cnt;
    logic [2:0]  state_dbg;

    int check_total = 0;
    int check_bad   = 0;
    int rej_model   = 0;

    ballot_sequencer #(.LOCKOUT_CYCLES(10), .DISPLAY_CYCLES(50)) dut (
        .clock         (clock),
        .reset         (reset),
        .session_open  (session_open),
        .ballot_arm    (ballot_arm),
        .vote_valid    (vote_valid),
        .vote_counts   (vote_counts),
        .vote_inc      (vote_inc),
        .ballot_ready  (ballot_ready),
        .busy          (busy),
        .total_ballots (total_ballots),
        .result_sel    (result_sel),
        .result_count  (result_count),
        .winner        (winner),
        .tie           (tie),
        .results_valid (results_valid),
        .rejected_cnt  (rejected_cnt),
        .state_dbg     (state_dbg)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_total++;
        if (got !== exp) begin
            check_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rej_exp();
        return AUDIT ? 32'(rej_model) : 32'd0;
    endfunction

    task automatic reject_one();
        if (rej_model < 255) rej_model++;
    endtask

    // Arm, press one-hot v, check the strobe, wait out the lockout.
    task automatic cast_vote(input logic [3:0] v);
        int guard;
        ballot_arm = 1'b1;
        step();
        ballot_arm = 1'b0;
        vote_valid = v;
        step();
        vote_valid = 4'd0;
        check("cast_inc", vote_inc, v);
        guard = 0;
        while (busy && guard < 40) begin
            step();
            guard++;
        end
        check("cast_idle", state_dbg, S_IDLE);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_inc"},   vote_inc, 0);
        check({tag, "_ready"}, ballot_ready, 0);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_total"}, total_ballots, 0);
        check({tag, "_sel"},   result_sel, 0);
        check({tag, "_win"},   winner, 0);
        check({tag, "_tie"},   tie, 0);
        check({tag, "_rv"},    results_valid, 0);
        check({tag, "_rej"},   rejected_cnt, 0);
        check({tag, "_state"}, state_dbg, S_CLOSED);
    endtask

    initial begin
        int busy_cycles;
        int inc_extra;
        reset        = 1'b1;
        session_open = 1'b0;
        ballot_arm   = 1'b0;
        vote_valid   = 4'd0;
        vote_counts  = {8'd5, 8'd9, 8'd9, 8'd2};
        step();
        step();
        check_all_zero("rst");
        check("rst_count", result_count, 2);

        // CLOSED ignores presses without counting them
        reset      = 1'b0;
        vote_valid = 4'b0001;
        step();
        vote_valid = 4'd0;
        check("closed_rej", rejected_cnt, 0);
        check("closed_state", state_dbg, S_CLOSED);

        session_open = 1'b1;
        step();
        check("open_state", state_dbg, S_IDLE);

        // press while unarmed
        vote_valid = 4'b0010;
        step();
        vote_valid = 4'd0;
        reject_one();
        check("idle_rej", rejected_cnt, rej_exp());
        check("idle_inc", vote_inc, 0);

        ballot_arm = 1'b1;
        step();
        ballot_arm = 1'b0;
        check("arm_state", state_dbg, S_ARMED);
        check("arm_ready", ballot_ready, 1);

        // ambiguous press stays armed
        vote_valid = 4'b0011;
        step();
        vote_valid = 4'd0;
        reject_one();
        check("multi_inc", vote_inc, 0);
        check("multi_rej", rejected_cnt, rej_exp());
        check("multi_ready", ballot_ready, 1);

        // re-arm has no effect
        ballot_arm = 1'b1;
        step();
        ballot_arm = 1'b0;
        check("rearm_state", state_dbg, S_ARMED);

        // accepted vote, latency 1, then lockout of 10 cycles
        vote_valid = 4'b0100;
        step();
        vote_valid = 4'd0;
        check("vote_inc", vote_inc, 4'b0100);
        check("vote_total", total_ballots, 1);
        check("vote_ready", ballot_ready, 0);
        busy_cycles = 0;
        inc_extra   = 0;
        while (busy && busy_cycles < 40) begin
            busy_cycles++;
            vote_valid = (busy_cycles == 3) ? 4'b1000 : 4'b0000;
            step();
            if (vote_inc != 4'd0) inc_extra++;
        end
        vote_valid = 4'd0;
        reject_one();
        check("busy_len", busy_cycles, 10);
        check("lock_inc", inc_extra, 0);
        check("lock_rej", rejected_cnt, rej_exp());
        check("lock_state", state_dbg, S_IDLE);
        check("lock_total", total_ballots, 1);

        cast_vote(4'b0001);
        check("second_total", total_ballots, 2);

        // closing while armed drops the same-cycle press
        ballot_arm = 1'b1;
        step();
        ballot_arm   = 1'b0;
        session_open = 1'b0;
        vote_valid   = 4'b0010;
        step();
        vote_valid = 4'd0;
        check("close_state", state_dbg, S_TALLY);
        check("close_inc", vote_inc, 0);
        check("close_total", total_ballots, 2);
        check("close_rej", rejected_cnt, rej_exp());

        // tally: cand0=2 cand1=9 cand2=9 cand3=5
        for (int i = 0; i < 3; i++) step();
        check("tally3_state", state_dbg, S_TALLY);
        check("tally3_rv", results_valid, 0);
        step();
        check("res_rv", results_valid, 1);
        check("res_win", winner, 1);
        check("res_tie", tie, 1);
        check("res_sel0", result_sel, 0);
        check("res_cnt0", result_count, 2);
        for (int i = 0; i < 49; i++) step();
        check("dwell_edge", result_sel, 0);
        step();
        check("res_sel1", result_sel, 1);
        check("res_cnt1", result_count, 9);
        for (int i = 0; i < 50; i++) step();
        check("res_sel2", result_sel, 2);
        check("res_cnt2", result_count, 9);
        for (int i = 0; i < 50; i++) step();
        check("res_sel3", result_sel, 3);
        check("res_cnt3", result_count, 5);
        for (int i = 0; i < 50; i++) step();
        check("res_wrap", result_sel, 0);

        // reopen keeps total
        session_open = 1'b1;
        step();
        check("reopen_state", state_dbg, S_IDLE);
        check("reopen_rv", results_valid, 0);
        check("reopen_total", total_ballots, 2);

        // second tally: cand0=8 cand1=8 cand2=4 cand3=30, tie must clear
        vote_counts  = {8'd30, 8'd4, 8'd8, 8'd8};
        session_open = 1'b0;
        step();
        check("idle_close", state_dbg, S_TALLY);
        for (int i = 0; i < 4; i++) step();
        check("res2_rv", results_valid, 1);
        check("res2_win", winner, 3);
        check("res2_tie", tie, 0);
        session_open = 1'b1;
        step();

        // saturate total_ballots
        for (int i = 0; i < 253; i++) cast_vote(4'(1 << (i % 4)));
        check("sat_total", total_ballots, 255);
        ballot_arm = 1'b1;
        step();
        ballot_arm = 1'b0;
        check("sat_arm_state", state_dbg, S_IDLE);
        check("sat_ready", ballot_ready, 0);

        // saturate rejected_cnt
        vote_valid = 4'b0001;
        for (int i = 0; i < 260; i++) begin
            step();
            reject_one();
        end
        vote_valid = 4'd0;
        check("sat_rej", rejected_cnt, rej_exp());

        // reset in the middle of a lockout
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        ballot_arm = 1'b1;
        step();
        ballot_arm = 1'b0;
        vote_valid = 4'b0010;
        step();
        vote_valid = 4'd0;
        check("pre_rst_busy", busy, 1);
        for (int i = 0; i < 3; i++) step();
        reset = 1'b1;
        step();
        check_all_zero("midlock");
        check("midlock_count", result_count, 8);
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", check_total, check_bad);
        $finish;
    end

endmodule
